uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/fifo_ram.sv | 27 ++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and helper types shared by the UART transmitter, its TX FIFO
// and the planned receiver.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = 4;

  typedef enum logic [1:0] {
    FIFO_OP_NONE  = 2'd0,
    FIFO_OP_WRITE = 2'd1,
    FIFO_OP_POP   = 2'd2,
    FIFO_OP_BOTH  = 2'd3
  } fifo_op_e;

  // Collapses the two handshakes of a cycle into the operation that moves the level.
  function automatic fifo_op_e fifo_op(input logic wr, input logic pop);
    fifo_op_e op;
    unique case ({pop, wr})
      2'b01:   op = FIFO_OP_WRITE;
      2'b10:   op = FIFO_OP_POP;
      2'b11:   op = FIFO_OP_BOTH;
      default: op = FIFO_OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x 8 storage array with one synchronous write port and an
// asynchronous read port; contents are never reset.
module fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter, with
// registered fill level, flush and a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_data_valid,
  input  logic                   tx_data_ready,
  output logic [AW:0]            level,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          wr_fire, pop_fire;
  fifo_op_e      op;

  assign wr_ready      = (level_q != FULL_LEVEL);
  assign tx_data_valid = (level_q != '0);
  assign level         = level_q;
  assign overflow      = overflow_q;

  // A flush cancels both handshakes, so the RAM is not written either.
  assign wr_fire  = wr_valid && wr_ready && !flush;
  assign pop_fire = tx_data_valid && tx_data_ready && !flush;
  assign op       = fifo_op(wr_fire, pop_fire);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case (op)
        FIFO_OP_WRITE: level_d = level_q + (AW+1)'(1);
        FIFO_OP_POP:   level_d = level_q - (AW+1)'(1);
        default:       level_d = level_q;
      endcase
      // Setting has priority so a refused write is never lost to a clear.
      if (wr_valid && !wr_ready) begin
        overflow_d = 1'b1;
      end else if (ovf_clr) begin
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_fire && !rst),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(tx_data)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scenario bench for uart_tx_fifo: a byte queue models the FIFO and every
// popped byte is checked against its front.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       flush = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready = 1'b0;
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .level        (level),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  // One clock with the given inputs; the queue model follows the edge.
  task automatic drive(input logic wv, input logic [7:0] wd, input logic rdy,
                       input logic fl, input logic clr);
    bit do_pop, do_wr, full;
    wr_valid = wv; wr_data = wd; tx_data_ready = rdy; flush = fl; ovf_clr = clr;
    @(posedge clk);
    full   = (exp_q.size() == 16);
    do_pop = (exp_q.size() != 0) && rdy && !fl;
    do_wr  = wv && !full && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (wv && full) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      if (do_pop) void'(exp_q.pop_front());
      if (do_wr) exp_q.push_back(wd);
    end
    @(negedge clk);
    wr_valid = 1'b0; tx_data_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic apply_reset(input logic wv, input logic fl, input logic rdy, input logic clr);
    rst = 1'b1; wr_valid = wv; wr_data = 8'hEE; flush = fl; tx_data_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0; flush = 1'b0; tx_data_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (tx_data_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", tx_data_valid);
    end
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_wr_ready: got %b expected 1", wr_ready);
    end
    vectors++;
    if (level !== 5'd0) begin
      miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_first_word();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h55 || level !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL first_word: got valid=%b data=%h level=%0d expected 1/55/1",
               tx_data_valid, tx_data, level);
    end
    vectors++;
    if (tx_data !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL first_pop: got %h expected %h", tx_data, exp_q[0]);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (tx_data_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL first_empty: got valid=%b level=%0d expected 0/0", tx_data_valid, level);
    end
  endtask

  task automatic test_in_order();
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (level !== 5'd3) begin
      miscompares++; $display("[TB] FAIL order_level: got %0d expected 3", level);
    end
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 10; k++) begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (tx_data_valid !== 1'b1 || tx_data !== exp_q[0]) begin
          miscompares++;
          $display("[TB] FAIL order_hold: got valid=%b data=%h expected 1/%h",
                   tx_data_valid, tx_data, exp_q[0]);
        end
      end
      vectors++;
      if (tx_data !== 8'(8'h41 + i)) begin
        miscompares++; $display("[TB] FAIL order_pop: got %h expected %h", tx_data, 8'(8'h41 + i));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (level !== 5'(2 - i)) begin
        miscompares++; $display("[TB] FAIL order_level: got %0d expected %0d", level, 2 - i);
      end
    end
    vectors++;
    if (tx_data_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL order_empty: got %b expected 0", tx_data_valid);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      vectors++;
      if (tx_data_valid !== 1'b1 || tx_data !== exp_q[0]) begin
        miscompares++;
        $display("[TB] FAIL drain_pop: got valid=%b data=%h expected 1/%h",
                 tx_data_valid, tx_data, exp_q[0]);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    vectors++;
    if (tx_data_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL drain_empty: got valid=%b level=%0d expected 0/0", tx_data_valid, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (wr_ready !== 1'b1) begin
        miscompares++; $display("[TB] FAIL fill_ready: got %b expected 1 at %0d", wr_ready, i);
      end
      drive(1'b1, 8'($urandom_range(0, 254)), 1'b0, 1'b0, 1'b0);
    end
    vectors++;
    if (wr_ready !== 1'b0 || level !== 5'd16 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_state: got ready=%b level=%0d ovf=%b expected 0/16/0",
               wr_ready, level, overflow);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      miscompares++;
      $display("[TB] FAIL ovf_set: got ovf=%b level=%0d expected 1/16", overflow, level);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (overflow !== exp_ovf) begin
      miscompares++; $display("[TB] FAIL ovf_set_wins: got %b expected %b", overflow, exp_ovf);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ovf_clr: got %b expected 0", overflow);
    end
    vectors++;
    if (tx_data !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL full_pop: got %h expected %h", tx_data, exp_q[0]);
    end
    drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (level !== 5'd15 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_wr_pop: got level=%0d ovf=%b expected 15/1", level, overflow);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 41; i++) begin
      vectors++;
      if (tx_data !== exp_q[0]) begin
        miscompares++; $display("[TB] FAIL wrap_pop %0d: got %h expected %h", i, tx_data, exp_q[0]);
      end
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        vectors++;
        if (level !== 5'd8) begin
          miscompares++; $display("[TB] FAIL simul_level: got %0d expected 8", level);
        end
      end
    end
    vectors++;
    if (level !== 5'd8) begin
      miscompares++; $display("[TB] FAIL wrap_level: got %0d expected 8", level);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (tx_data !== exp_q[0]) begin
        miscompares++; $display("[TB] FAIL flush_pre_pop: got %h expected %h", tx_data, exp_q[0]);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    vectors++;
    if (level !== 5'd5 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_pre: got level=%0d ovf=%b expected 5/1", level, overflow);
    end
    drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (level !== 5'd0 || tx_data_valid !== 1'b0 || wr_ready !== 1'b1 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_state: got level=%0d valid=%b ready=%b ovf=%b expected 0/0/1/1",
               level, tx_data_valid, wr_ready, overflow);
    end
    drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (tx_data !== 8'h3C || level !== 5'd1 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_after: got data=%h level=%0d ovf=%b expected 3c/1/0",
               tx_data, level, overflow);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    apply_reset(1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (level !== 5'd0 || tx_data_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset: got level=%0d valid=%b expected 0/0", level, tx_data_valid);
    end
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (tx_data !== 8'h77 || level !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL midreset_write: got data=%h level=%0d expected 77/1", tx_data, level);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_in_order();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
